// File: rtl/state_pack_unmask_if.sv
// Handshake and data bundle for the Kyber512 state unmasking block.
// The master drives the shares and the start request; the slave returns the result.
interface state_pack_unmask_if;
    logic         enable;
    logic [127:0] s1;
    logic [127:0] s2;
    logic         function_done;
    logic         busy;
    logic [127:0] s;
    logic         range_err;

    modport master (
        output enable, s1, s2,
        input  function_done, busy, s, range_err
    );

    modport slave (
        input  enable, s1, s2,
        output function_done, busy, s, range_err
    );
endinterface

// File: rtl/state_pack_unmask.sv
// Recombines two arithmetic shares of a Kyber512 state word, one lane per cycle.
// Optional sticky out-of-range flag enabled by UNMASK_RANGE_CHECK_EN.
module state_pack_unmask #(
    parameter int KYBER_Q = 3329
) (
    input logic                 clk,
    input logic                 rst_n,
    state_pack_unmask_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    typedef logic [7:0][15:0] lanes_t;

    localparam logic [16:0] Q = 17'(KYBER_Q);

    state_t      state_q, state_d;
    lanes_t      s1_q, s1_d;
    lanes_t      s2_q, s2_d;
    lanes_t      s_q, s_d;
    logic [2:0]  m_q, m_d;
    logic        done_q, done_d;
    logic [16:0] sum;
    logic        ge;
    logic [15:0] res;

    // Lane 0 sits in the top 16 bits, so lane m is packed element 7-m = ~m.
    always_comb begin
        sum = {1'b0, s1_q[~m_q]} + {1'b0, s2_q[~m_q]};
        ge  = (sum >= Q);
        res = ge ? 16'(sum - Q) : sum[15:0];
    end

`ifdef UNMASK_RANGE_CHECK_EN
    logic [16:0] r;
    logic        over;
    logic        err_q, err_d;

    always_comb begin
        r    = ge ? (sum - Q) : sum;
        over = (r >= Q);
    end

    assign bus.range_err = err_q;
`else
    assign bus.range_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        s_d     = s_q;
        m_d     = m_q;
        done_d  = 1'b0;
`ifdef UNMASK_RANGE_CHECK_EN
        err_d   = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.enable) begin
                    s1_d    = bus.s1;
                    s2_d    = bus.s2;
                    m_d     = 3'd0;
`ifdef UNMASK_RANGE_CHECK_EN
                    err_d   = 1'b0;
`endif
                    state_d = CALC;
                end
            end
            CALC: begin
                s_d[~m_q] = res;
                m_d       = m_q + 3'd1;
`ifdef UNMASK_RANGE_CHECK_EN
                err_d     = err_q | over;
`endif
                if (m_q == 3'd7) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s1_q    <= '0;
            s2_q    <= '0;
            s_q     <= '0;
            m_q     <= 3'd0;
            done_q  <= 1'b0;
`ifdef UNMASK_RANGE_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            s_q     <= s_d;
            m_q     <= m_d;
            done_q  <= done_d;
`ifdef UNMASK_RANGE_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    assign bus.s             = s_q;
    assign bus.function_done = done_q;
    assign bus.busy          = (state_q != IDLE);
endmodule

// File: tb/tb_state_pack_unmask.sv
// Self-checking bench for state_pack_unmask: vector table, corner sequences,
// and randomized mask/unmask round trips against a modular-arithmetic model.
module tb_state_pack_unmask;
    localparam int Q = 3329;
`ifdef UNMASK_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    state_pack_unmask_if bus();

    state_pack_unmask #(.KYBER_Q(Q)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        string        name;
        logic [127:0] s1;
        logic [127:0] s2;
        logic [127:0] exp;
        logic         err;
    } vec_t;

    vec_t tab[5];

    task automatic chk(input string name, input logic [127:0] got,
                       input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    // Reference: each lane is (a+b) with at most one subtraction of q, kept mod 2^16.
    function automatic void ref_unmask(input logic [127:0] a, input logic [127:0] b,
                                       output logic [127:0] r, output logic e);
        int x, y, v;
        e = 1'b0;
        r = '0;
        for (int m = 0; m < 8; m++) begin
            x = int'(a[127-16*m -: 16]);
            y = int'(b[127-16*m -: 16]);
            v = x + y;
            if (v >= Q) v = v - Q;
            if (v >= Q) e = 1'b1;
            r[127-16*m -: 16] = 16'(v);
        end
        if (!RC) e = 1'b0;
    endfunction

    task automatic run_op(input logic [127:0] a, input logic [127:0] b,
                          output logic [127:0] got, output logic err,
                          output int lat, output logic busy0);
        @(negedge clk);
        bus.s1 = a;
        bus.s2 = b;
        bus.enable = 1'b1;
        @(posedge clk);
        #1;
        bus.enable = 1'b0;
        busy0 = bus.busy;
        lat = 0;
        while (bus.function_done !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        got = bus.s;
        err = bus.range_err;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [127:0] got, exp, a, b, x;
        logic         err, eexp, busy0;
        int           lat, pulses, t0, t1, cyc, mk, xv;

        tab[0] = '{"basic", {8{16'd1000}}, {8{16'd2000}}, {8{16'd3000}}, 1'b0};
        tab[1] = '{"reduce",
                   {16'd3000, 16'd3328, 16'd0, 16'd3328, {4{16'd1}}},
                   {16'd3000, 16'd1,    16'd0, 16'd3328, {4{16'd2}}},
                   {16'd2671, 16'd0,    16'd0, 16'd3327, {4{16'd3}}}, 1'b0};
        tab[2] = '{"range", {80'h0, 16'hFFFF, 32'h0}, {80'h0, 16'hFFFF, 32'h0},
                   {80'h0, 16'hF2FD, 32'h0}, RC};
        tab[3] = '{"clear", {8{16'd1000}}, {8{16'd2000}}, {8{16'd3000}}, 1'b0};
        tab[4] = '{"zero", '0, '0, '0, 1'b0};

        bus.enable = 1'b0;
        bus.s1 = '0;
        bus.s2 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s", bus.s, '0);
        chk("rst_flags", {125'd0, bus.function_done, bus.busy, bus.range_err}, '0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_op(tab[i].s1, tab[i].s2, got, err, lat, busy0);
            chk({tab[i].name, "_s"}, got, tab[i].exp);
            chk({tab[i].name, "_err"}, 128'(err), 128'(tab[i].err));
            chk({tab[i].name, "_lat"}, 128'(lat), 128'd8);
            chk({tab[i].name, "_busy"}, 128'(busy0), 128'd1);
            chk({tab[i].name, "_idle"}, 128'(bus.busy), 128'd0);
        end

        // Inputs change and enable stays high during CALC.
        @(negedge clk);
        bus.s1 = tab[1].s1;
        bus.s2 = tab[1].s2;
        bus.enable = 1'b1;
        @(posedge clk);
        #1;
        bus.s1 = '1;
        bus.s2 = '1;
        repeat (4) @(posedge clk);
        #1;
        bus.enable = 1'b0;
        pulses = 0;
        got = '0;
        for (int k = 0; k < 10; k++) begin
            if (bus.function_done === 1'b1) begin
                pulses++;
                got = bus.s;
            end
            @(posedge clk);
            #1;
        end
        chk("hold_s", got, tab[1].exp);
        chk("hold_pulses", 128'(pulses), 128'd1);

        // Reset after lane 4 is written.
        @(negedge clk);
        bus.s1 = tab[0].s1;
        bus.s2 = tab[0].s2;
        bus.enable = 1'b1;
        @(posedge clk);
        #1;
        bus.enable = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_s", bus.s, '0);
        chk("midrst_busy", 128'(bus.busy), 128'd0);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            if (bus.function_done === 1'b1) pulses++;
            @(posedge clk);
            #1;
        end
        chk("midrst_nodone", 128'(pulses), 128'd0);
        run_op(tab[1].s1, tab[1].s2, got, err, lat, busy0);
        chk("postrst_s", got, tab[1].exp);
        chk("postrst_lat", 128'(lat), 128'd8);

        // Randomized mask then unmask round trips.
        for (int n = 0; n < 25; n++) begin
            for (int m = 0; m < 8; m++) begin
                xv = int'($urandom_range(0, Q - 1));
                mk = int'($urandom_range(0, Q - 1));
                x[127-16*m -: 16] = 16'(xv);
                a[127-16*m -: 16] = 16'(mk);
                b[127-16*m -: 16] = 16'((xv + Q - mk) % Q);
            end
            run_op(a, b, got, err, lat, busy0);
            chk("rt_s", got, x);
            chk("rt_err", 128'(err), 128'd0);
        end

        // Arbitrary 16-bit shares, including out-of-range ones.
        for (int n = 0; n < 10; n++) begin
            a = {$urandom, $urandom, $urandom, $urandom};
            b = {$urandom, $urandom, $urandom, $urandom};
            ref_unmask(a, b, exp, eexp);
            run_op(a, b, got, err, lat, busy0);
            chk("rand_s", got, exp);
            chk("rand_err", 128'(err), 128'(eexp));
        end

        // Back-to-back period with enable held high.
        for (int m = 0; m < 8; m++) begin
            xv = int'($urandom_range(0, Q - 1));
            mk = int'($urandom_range(0, Q - 1));
            x[127-16*m -: 16] = 16'(xv);
            a[127-16*m -: 16] = 16'(mk);
            b[127-16*m -: 16] = 16'((xv + Q - mk) % Q);
        end
        @(negedge clk);
        bus.s1 = a;
        bus.s2 = b;
        bus.enable = 1'b1;
        t0 = -1;
        t1 = -1;
        cyc = 0;
        got = '0;
        while (t1 < 0 && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.function_done === 1'b1) begin
                if (t0 < 0) begin
                    t0 = cyc;
                    got = bus.s;
                end else begin
                    t1 = cyc;
                end
            end
        end
        bus.enable = 1'b0;
        chk("b2b_s", got, x);
        chk("b2b_period", 128'(t1 - t0), 128'd10);
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
